rv_mem_arbiter: RTL and testbench

- Shares one single-port unified memory between two requesters: the instruction-fetch path (port I) and the load/store data path (port D) of the RV core.
- Round-robin arbiter with one outstanding transaction at a time.
- Request/acknowledge handshake toward each requester; request/grant plus read-valid handshake toward memory.
- Per-transaction timeout, so a dead memory cannot hang the core.

---
 rtl/rv_arb_pkg.sv | 24 ++
 rtl/rv_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 tb/tb_rv_mem_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_arb_pkg.sv
// ----------------------------------------------------------------------------
// rv_arb_pkg
// Shared types and defaults for the RV unified-memory arbiter.
//   state_e         : arbiter FSM states (IDLE, REQ, WAIT, RESP)
//   owner_e         : which requester owns the memory (OWN_I = fetch, OWN_D = data)
//   DEFAULT_TIMEOUT : default cycle budget for REQ+WAIT before an abort
// ----------------------------------------------------------------------------
package rv_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/rv_mem_arbiter.sv
// ----------------------------------------------------------------------------
// rv_mem_arbiter
// Round-robin arbiter sharing one single-port memory between the instruction
// fetch port (I) and the load/store port (D). Only one transaction is in
// flight at a time; each one is bounded by a timeout so a dead memory cannot
// hang the core. Every output is registered.
//
// Ports
//   clk, rst                     : clock (rising edge), synchronous active-high reset
//   i_req/i_addr                 : fetch request, held until i_ack
//   i_ack/i_rdata/i_err          : one-cycle completion pulse, data, timeout flag
//   d_req/d_we/d_be/d_addr/d_wdata : data request, held until d_ack
//   d_ack/d_rdata/d_err          : one-cycle completion pulse, data, timeout flag
//   m_req/m_we/m_be/m_addr/m_wdata : memory request toward the single-port memory
//   m_gnt                        : memory accepted the request
//   m_rvalid/m_rdata             : memory response (completes reads and writes)
//   owner                        : current or last owner (0 = I, 1 = D)
// ----------------------------------------------------------------------------
module rv_mem_arbiter
    import rv_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ack,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_err,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,

    output logic                m_req,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_gnt,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata,

    output logic                owner
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    // The counter value seen during the TIMEOUT-th cycle of REQ+WAIT.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    state_e             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    owner_e             last_grant_reg, last_grant_next;
    owner_e             owner_reg, owner_next;

    logic               m_req_reg, m_req_next;
    logic               m_we_reg, m_we_next;
    logic [BE_W-1:0]    m_be_reg, m_be_next;
    logic [ADDR_W-1:0]  m_addr_reg, m_addr_next;
    logic [DATA_W-1:0]  m_wdata_reg, m_wdata_next;

    logic               i_ack_reg, i_ack_next;
    logic [DATA_W-1:0]  i_rdata_reg, i_rdata_next;
    logic               i_err_reg, i_err_next;
    logic               d_ack_reg, d_ack_next;
    logic [DATA_W-1:0]  d_rdata_reg, d_rdata_next;
    logic               d_err_reg, d_err_next;

    logic               any_req;
    logic               sel_d;
    logic               in_flight;
    logic               complete;
    logic               expired;
    logic [DATA_W-1:0]  resp_data;

    // On a tie the port that was not served last wins.
    assign any_req   = i_req | d_req;
    assign sel_d     = d_req & (~i_req | (last_grant_reg == OWN_I));
    assign in_flight = (state_reg == REQ) || (state_reg == WAIT);

    // A response only counts once the request has been granted: either in
    // the grant cycle itself or later while waiting.
    assign complete  = ((state_reg == REQ)  && m_gnt && m_rvalid) ||
                       ((state_reg == WAIT) && m_rvalid);

    // Completion in the last allowed cycle beats the timeout.
    assign expired   = in_flight && (cnt_reg == CNT_LAST) && !complete;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            last_grant_reg <= OWN_D;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            last_grant_reg <= last_grant_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (any_req) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
                if (complete || expired) begin
                    state_next = RESP;
                end else if (m_gnt) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
                if (complete || expired) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                last_grant_next = owner_reg;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: computes the next value of every registered output.
    // ------------------------------------------------------------------
    always_comb begin
        owner_next   = owner_reg;
        m_req_next   = m_req_reg;
        m_we_next    = m_we_reg;
        m_be_next    = m_be_reg;
        m_addr_next  = m_addr_reg;
        m_wdata_next = m_wdata_reg;
        i_ack_next   = 1'b0;
        i_rdata_next = i_rdata_reg;
        i_err_next   = i_err_reg;
        d_ack_next   = 1'b0;
        d_rdata_next = d_rdata_reg;
        d_err_next   = d_err_reg;
        resp_data    = '0;
        case (state_reg)
            IDLE: begin
                m_req_next = any_req;
                if (any_req) begin
                    // Latch the winner's fields so the requester may change
                    // them freely once selected. Fetches are full-word reads.
                    owner_next   = sel_d ? OWN_D : OWN_I;
                    m_addr_next  = sel_d ? d_addr : i_addr;
                    m_we_next    = sel_d & d_we;
                    m_be_next    = sel_d ? d_be : {BE_W{1'b1}};
                    m_wdata_next = sel_d ? d_wdata : '0;
                end
            end
            REQ, WAIT: begin
                // Writes and aborted transactions return zero data.
                resp_data = (expired || m_we_reg) ? '0 : m_rdata;
                if (complete || expired) begin
                    m_req_next = 1'b0;
                    if (owner_reg == OWN_D) begin
                        d_ack_next   = 1'b1;
                        d_rdata_next = resp_data;
                        d_err_next   = expired;
                    end else begin
                        i_ack_next   = 1'b1;
                        i_rdata_next = resp_data;
                        i_err_next   = expired;
                    end
                end else if ((state_reg == REQ) && m_gnt) begin
                    m_req_next = 1'b0;
                end
            end
            default: begin
                m_req_next = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_reg   <= OWN_I;
            m_req_reg   <= 1'b0;
            m_we_reg    <= 1'b0;
            m_be_reg    <= '0;
            m_addr_reg  <= '0;
            m_wdata_reg <= '0;
            i_ack_reg   <= 1'b0;
            i_rdata_reg <= '0;
            i_err_reg   <= 1'b0;
            d_ack_reg   <= 1'b0;
            d_rdata_reg <= '0;
            d_err_reg   <= 1'b0;
        end else begin
            owner_reg   <= owner_next;
            m_req_reg   <= m_req_next;
            m_we_reg    <= m_we_next;
            m_be_reg    <= m_be_next;
            m_addr_reg  <= m_addr_next;
            m_wdata_reg <= m_wdata_next;
            i_ack_reg   <= i_ack_next;
            i_rdata_reg <= i_rdata_next;
            i_err_reg   <= i_err_next;
            d_ack_reg   <= d_ack_next;
            d_rdata_reg <= d_rdata_next;
            d_err_reg   <= d_err_next;
        end
    end

    assign owner   = owner_reg;
    assign m_req   = m_req_reg;
    assign m_we    = m_we_reg;
    assign m_be    = m_be_reg;
    assign m_addr  = m_addr_reg;
    assign m_wdata = m_wdata_reg;
    assign i_ack   = i_ack_reg;
    assign i_rdata = i_rdata_reg;
    assign i_err   = i_err_reg;
    assign d_ack   = d_ack_reg;
    assign d_rdata = d_rdata_reg;
    assign d_err   = d_err_reg;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rv_mem_arbiter
// Self-checking bench for rv_mem_arbiter (TIMEOUT = 8). The bench plays both
// requesters and the memory. Expected results come from a transaction-level
// model: arbitration by "who was served last", a word-array memory updated
// with the requester-side byte enables, and a latency/timeout prediction from
// the grant and response delays the bench chooses for the memory.
// Latency is counted in clock edges from the edge that samples the request in
// IDLE to the edge after which the ack is visible (IDLE, REQ.., RESP).
// ----------------------------------------------------------------------------
module tb_rv_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int TO = 8;

    logic          clk;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          i_err;
    logic          d_req;
    logic          d_we;
    logic [BW-1:0] d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          d_err;
    logic          m_req;
    logic          m_we;
    logic [BW-1:0] m_be;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_gnt;
    logic          m_rvalid;
    logic [DW-1:0] m_rdata;
    logic          owner;

    rv_mem_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_ack    (i_ack),
        .i_rdata  (i_rdata),
        .i_err    (i_err),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_be     (d_be),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_be     (m_be),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_gnt    (m_gnt),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata),
        .owner    (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    logic [31:0] model_mem [64];   // what the requesters expect memory to hold
    logic [31:0] resp_mem  [64];   // what the memory side actually holds
    logic        last_d;           // model: 1 when D was served last

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        model_mem[a[7:2]] = d;
        resp_mem[a[7:2]]  = d;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, 64'({i_ack, i_err, d_ack, d_err, m_req, m_we, m_be, owner}), 64'(0));
        check({tag, "_maddr"}, 64'(m_addr), 64'(0));
        check({tag, "_mwdata"}, 64'(m_wdata), 64'(0));
        check({tag, "_irdata"}, 64'(i_rdata), 64'(0));
        check({tag, "_drdata"}, 64'(d_rdata), 64'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
        m_gnt = 1'b0;
        m_rvalid = 1'b0;
        step();
        step();
        rst = 1'b0;
        last_d = 1'b1;
    endtask

    task automatic new_i();
        i_req  = 1'b1;
        i_addr = $urandom & 32'hFFFF_FFFC;
    endtask

    task automatic new_d();
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_be    = 4'($urandom_range(0, 15));
        d_addr  = $urandom & 32'hFFFF_FFFC;
        d_wdata = $urandom;
    endtask

    // Memory-side response for the current m_* request.
    task automatic mem_respond();
        m_rvalid = 1'b1;
        if (m_we) begin
            m_rdata = $urandom;   // garbage: a write must return zero to the requester
            for (int b = 0; b < BW; b++)
                if (m_be[b]) resp_mem[m_addr[7:2]][8*b +: 8] = m_wdata[8*b +: 8];
        end else begin
            m_rdata = resp_mem[m_addr[7:2]];
        end
    endtask

    // One transaction. Requests/fields must already be driven and the DUT in
    // IDLE. gd = REQ cycles before grant (-1 = never), rd = cycles after the
    // grant cycle before m_rvalid.
    task automatic run_txn(input int gd, input int rd);
        logic        exp_d;
        logic        ewe;
        logic [31:0] ea;
        logic [31:0] ewd;
        logic [3:0]  ebe;
        logic [31:0] exp_rdata;
        bit          tmo;
        bit          ack_seen;
        int          exp_lat;
        int          edges;
        int          reqc;
        int          rc;
        int          phase;

        exp_d = d_req && (!i_req || !last_d);
        if (exp_d) begin
            ea = d_addr; ewe = d_we; ebe = d_be; ewd = d_wdata;
        end else begin
            ea = i_addr; ewe = 1'b0; ebe = 4'hF; ewd = '0;
        end
        tmo       = (gd < 0) || (gd + 1 + rd > TO);
        exp_lat   = tmo ? TO + 1 : gd + 1 + rd + 1;
        exp_rdata = (tmo || ewe) ? 32'h0 : model_mem[ea[7:2]];
        if (!tmo && ewe)
            for (int b = 0; b < BW; b++)
                if (ebe[b]) model_mem[ea[7:2]][8*b +: 8] = ewd[8*b +: 8];
        last_d = exp_d;

        edges = 0; reqc = 0; rc = 0; phase = 0; ack_seen = 0;
        while (!ack_seen && edges < TO + 6) begin
            if (phase == 0 && m_req) begin
                check("m_addr", 64'(m_addr), 64'(ea));
                check("m_we", 64'(m_we), 64'(ewe));
                check("m_be", 64'(m_be), 64'(ebe));
                if (ewe) check("m_wdata", 64'(m_wdata), 64'(ewd));
                if (reqc == gd) begin
                    m_gnt = 1'b1;
                    phase = 1;
                end
                reqc++;
            end else if (phase == 1) begin
                rc++;
            end
            if (phase == 1 && rc == rd) begin
                mem_respond();
                phase = 2;
            end
            @(posedge clk);
            edges++;
            #1;
            if (edges == 1) begin
                // Selected requester changes its fields; the DUT must not care.
                if (exp_d) begin
                    d_addr = $urandom; d_wdata = $urandom;
                    d_be = 4'($urandom_range(0, 15)); d_we = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 3) == 0) d_req = 1'b0;
                end else begin
                    i_addr = $urandom;
                    if ($urandom_range(0, 3) == 0) i_req = 1'b0;
                end
            end
            @(negedge clk);
            m_gnt = 1'b0;
            m_rvalid = 1'b0;
            if (i_ack || d_ack) ack_seen = 1;
        end

        check("ack_seen", 64'(ack_seen), 64'(1));
        if (ack_seen) begin
            check("ack_port", 64'({i_ack, d_ack}), exp_d ? 64'(2'b01) : 64'(2'b10));
            check("latency", 64'(edges), 64'(exp_lat));
            check("owner", 64'(owner), 64'(exp_d));
            check("m_req_off", 64'(m_req), 64'(0));
            if (exp_d) begin
                check("d_rdata", 64'(d_rdata), 64'(exp_rdata));
                check("d_err", 64'(d_err), 64'(tmo));
                d_req = 1'b0;
            end else begin
                check("i_rdata", 64'(i_rdata), 64'(exp_rdata));
                check("i_err", 64'(i_err), 64'(tmo));
                i_req = 1'b0;
            end
            step();
            check("ack_pulse", 64'({i_ack, d_ack}), 64'(0));
            check("rdata_hold", exp_d ? 64'(d_rdata) : 64'(i_rdata), 64'(exp_rdata));
        end else begin
            do_reset();
        end
        txn_no++;
        $display("txn %0d port=%s gd=%0d rd=%0d we=%0b addr=0x%08h exp_err=%0b exp_rdata=0x%08h lat=%0d",
                 txn_no, exp_d ? "D" : "I", gd, rd, ewe, ea, tmo, exp_rdata, edges);
    endtask

    initial begin
        int gd;
        int rd;

        rst = 1'b1; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        for (int k = 0; k < 64; k++) begin
            model_mem[k] = $urandom;
            resp_mem[k]  = model_mem[k];
        end
        @(negedge clk);
        do_reset();
        check_zero("reset");

        // Lone fetch, grant at once, response two cycles later.
        preload(32'h100, 32'h0050_0093);
        i_req = 1'b1; i_addr = 32'h100;
        run_txn(0, 2);

        // Store that never gets granted while a fetch waits; fetch then proceeds.
        i_req = 1'b1; i_addr = 32'h44;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h48; d_wdata = 32'h1234_5678;
        run_txn(-1, 0);
        run_txn(0, 1);

        // Store with delayed grant.
        d_req = 1'b1; d_we = 1'b1; d_be = 4'h3; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF;
        run_txn(3, 1);

        // Completion in the last allowed cycle, then one cycle too late.
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h2004;
        run_txn(0, TO - 1);
        d_req = 1'b1; d_addr = 32'h2008;
        run_txn(1, TO - 1);

        // Grant and response together: shortest path.
        preload(32'h80, 32'hCAFE_F00D);
        i_req = 1'b1; i_addr = 32'h80;
        run_txn(0, 0);

        // Reset while waiting for the response, then a late m_rvalid.
        i_req = 1'b1; i_addr = 32'h40;
        step();
        m_gnt = 1'b1;
        step();
        m_gnt = 1'b0;
        rst = 1'b1;
        i_req = 1'b0;
        step();
        rst = 1'b0;
        m_rvalid = 1'b1;
        m_rdata = 32'h1234_5678;
        step();
        m_rvalid = 1'b0;
        check_zero("rst_wait");
        for (int k = 0; k < 3; k++) begin
            step();
            check("rst_no_ack", 64'({i_ack, d_ack}), 64'(0));
        end
        last_d = 1'b1;
        new_i(); new_d();
        run_txn(0, 1);
        check("rst_tie_owner", 64'(owner), 64'(0));

        // Both ports requesting continuously from reset: strict alternation.
        do_reset();
        new_i(); new_d();
        for (int k = 0; k < 4; k++) begin
            if (!i_req) new_i();
            if (!d_req) new_d();
            run_txn(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            check("rr_order", 64'(owner), 64'(k % 2));
        end

        // Randomized traffic.
        for (int t = 0; t < 120; t++) begin
            if (!i_req && $urandom_range(0, 1) == 1) new_i();
            if (!d_req && $urandom_range(0, 1) == 1) new_d();
            if (!i_req && !d_req) begin
                if ($urandom_range(0, 1) == 1) new_i();
                else new_d();
            end
            gd = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
            rd = int'($urandom_range(0, 4));
            run_txn(gd, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
